// File: rtl/axis_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with show-ahead output and fill-level status.
// TDATA and TLAST are stored together. The output beat is taken from storage only, so nothing passes straight through from input to output.
module axis_sync_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [DATA_W-1:0] S_TDATA,
    input  logic              S_TLAST,
    input  logic              S_TVALID,
    output logic              S_TREADY,
    output logic [DATA_W-1:0] M_TDATA,
    output logic              M_TLAST,
    output logic              M_TVALID,
    input  logic              M_TREADY,
    output logic [ADDR_W:0]   COUNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              ALMOST_FULL
);

    localparam logic [ADDR_W:0]   DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AF_C    = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              af_q, af_d;
    logic              push_s, pop_s;

    // The handshakes depend only on registered flags. When the FIFO is full, a write is refused even if a beat is popped on the same edge.
    assign push_s = S_TVALID & ~full_q;
    assign pop_s  = M_TREADY & ~empty_q;

    // Next-state logic for the pointers, the fill count and the decoded status flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
    end

    // Control state. An asynchronous reset discards every stored beat.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
        end
    end

    // Beat storage. It has no reset; the empty flag masks any stale contents.
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {S_TLAST, S_TDATA};
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Show-ahead head beat, forced to zero while the FIFO is empty
    always_comb begin
        if (empty_q) begin
            M_TDATA = '0;
            M_TLAST = 1'b0;
        end else begin
            M_TDATA = mem_q[rd_ptr_q][DATA_W-1:0];
            M_TLAST = mem_q[rd_ptr_q][DATA_W];
        end
    end

    assign S_TREADY    = ~full_q;
    assign M_TVALID    = ~empty_q;
    assign COUNT       = count_q;
    assign FULL        = full_q;
    assign EMPTY       = empty_q;
    assign ALMOST_FULL = af_q;

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed self-checking bench for axis_sync_fifo (DATA_W=32, DEPTH=8, AF_LEVEL=6).
module tb_axis_sync_fifo;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic [31:0] S_TDATA = 32'd0;
    logic        S_TLAST = 1'b0;
    logic        S_TVALID = 1'b0;
    logic        S_TREADY;
    logic [31:0] M_TDATA;
    logic        M_TLAST;
    logic        M_TVALID;
    logic        M_TREADY = 1'b0;
    logic [3:0]  COUNT;
    logic        FULL, EMPTY, ALMOST_FULL;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axis_sync_fifo #(.DATA_W(32), .DEPTH(8), .AF_LEVEL(6)) dut (
        .ACLK(ACLK), .ARST(ARST),
        .S_TDATA(S_TDATA), .S_TLAST(S_TLAST), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
        .M_TDATA(M_TDATA), .M_TLAST(M_TLAST), .M_TVALID(M_TVALID), .M_TREADY(M_TREADY),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARST = 1'b1;
        tick();
        total_cnt++; if (S_TREADY !== 1'b1) $display("FAIL reset_tready got=%0b exp=1", S_TREADY); else pass_cnt++;
        total_cnt++; if (M_TVALID !== 1'b0) $display("FAIL reset_tvalid got=%0b exp=0", M_TVALID); else pass_cnt++;
        total_cnt++; if (EMPTY !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", EMPTY); else pass_cnt++;
        total_cnt++; if (COUNT !== 4'd0) $display("FAIL reset_count got=%0d exp=0", COUNT); else pass_cnt++;
        total_cnt++; if (M_TDATA !== 32'd0) $display("FAIL reset_tdata got=%h exp=0", M_TDATA); else pass_cnt++;
        total_cnt++; if ({FULL, ALMOST_FULL, M_TLAST} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {FULL, ALMOST_FULL, M_TLAST}); else pass_cnt++;
        ARST = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        S_TDATA = 32'hDEADBEEF; S_TLAST = 1'b1; S_TVALID = 1'b1; M_TREADY = 1'b1;
        tick();
        S_TVALID = 1'b0; S_TLAST = 1'b0;
        total_cnt++; if (M_TVALID !== 1'b1) $display("FAIL single_valid got=%0b exp=1", M_TVALID); else pass_cnt++;
        total_cnt++; if (M_TDATA !== 32'hDEADBEEF) $display("FAIL single_data got=%h exp=deadbeef", M_TDATA); else pass_cnt++;
        total_cnt++; if (M_TLAST !== 1'b1) $display("FAIL single_last got=%0b exp=1", M_TLAST); else pass_cnt++;
        total_cnt++; if (COUNT !== 4'd1) $display("FAIL single_count1 got=%0d exp=1", COUNT); else pass_cnt++;
        tick();
        total_cnt++; if (COUNT !== 4'd0) $display("FAIL single_count0 got=%0d exp=0", COUNT); else pass_cnt++;
        total_cnt++; if (M_TVALID !== 1'b0) $display("FAIL single_drained got=%0b exp=0", M_TVALID); else pass_cnt++;
        M_TREADY = 1'b0;
    endtask

    task automatic test_fill();
        M_TREADY = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            S_TDATA = 32'(i); S_TLAST = (i == 8); S_TVALID = 1'b1;
            tick();
            total_cnt++; if (COUNT !== 4'(i)) $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, COUNT, i); else pass_cnt++;
            total_cnt++; if (ALMOST_FULL !== (i >= 6)) $display("FAIL fill_af i=%0d got=%0b exp=%0b", i, ALMOST_FULL, (i >= 6)); else pass_cnt++;
            total_cnt++; if (FULL !== (i == 8)) $display("FAIL fill_full i=%0d got=%0b exp=%0b", i, FULL, (i == 8)); else pass_cnt++;
            total_cnt++; if (M_TDATA !== 32'd1) $display("FAIL fill_head_stable i=%0d got=%h exp=1", i, M_TDATA); else pass_cnt++;
        end
        S_TDATA = 32'h9; S_TLAST = 1'b0;
        tick();
        total_cnt++; if (COUNT !== 4'd8) $display("FAIL fill_overflow_count got=%0d exp=8", COUNT); else pass_cnt++;
        total_cnt++; if (S_TREADY !== 1'b0) $display("FAIL fill_tready got=%0b exp=0", S_TREADY); else pass_cnt++;
        S_TVALID = 1'b0;
        M_TREADY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total_cnt++; if (M_TDATA !== 32'(i)) $display("FAIL drain_data i=%0d got=%h exp=%h", i, M_TDATA, i); else pass_cnt++;
            total_cnt++; if (M_TLAST !== (i == 8)) $display("FAIL drain_last i=%0d got=%0b exp=%0b", i, M_TLAST, (i == 8)); else pass_cnt++;
            tick();
        end
        total_cnt++; if (EMPTY !== 1'b1) $display("FAIL drain_empty got=%0b exp=1", EMPTY); else pass_cnt++;
        total_cnt++; if (COUNT !== 4'd0) $display("FAIL drain_no_underflow got=%0d exp=0", COUNT); else pass_cnt++;
        M_TREADY = 1'b0;
    endtask

    task automatic test_wrap_simultaneous();
        logic [31:0] exp_q[$];
        M_TREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            S_TDATA = 32'hA0 + 32'(i); S_TVALID = 1'b1;
            exp_q.push_back(S_TDATA);
            tick();
        end
        total_cnt++; if (COUNT !== 4'd3) $display("FAIL wrap_pre_count got=%0d exp=3", COUNT); else pass_cnt++;
        M_TREADY = 1'b1;
        for (int i = 0; i < 32; i++) begin
            S_TDATA = 32'h100 + 32'(i);
            exp_q.push_back(S_TDATA);
            total_cnt++; if (M_TDATA !== exp_q[0]) $display("FAIL wrap_data i=%0d got=%h exp=%h", i, M_TDATA, exp_q[0]); else pass_cnt++;
            void'(exp_q.pop_front());
            tick();
            total_cnt++; if (COUNT !== 4'd3) $display("FAIL wrap_count i=%0d got=%0d exp=3", i, COUNT); else pass_cnt++;
        end
        S_TVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (M_TDATA !== 32'h11D + 32'(i)) $display("FAIL wrap_tail i=%0d got=%h exp=%h", i, M_TDATA, 32'h11D + 32'(i)); else pass_cnt++;
            tick();
        end
        total_cnt++; if (EMPTY !== 1'b1) $display("FAIL wrap_empty got=%0b exp=1", EMPTY); else pass_cnt++;
        M_TREADY = 1'b0;
    endtask

    task automatic test_full_pop_same_edge();
        M_TREADY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            S_TDATA = 32'h200 + 32'(i); S_TVALID = 1'b1;
            tick();
        end
        total_cnt++; if (FULL !== 1'b1) $display("FAIL fpop_full got=%0b exp=1", FULL); else pass_cnt++;
        S_TDATA = 32'h2FF; S_TVALID = 1'b1; M_TREADY = 1'b1;
        tick();
        total_cnt++; if (COUNT !== 4'd7) $display("FAIL fpop_count7 got=%0d exp=7", COUNT); else pass_cnt++;
        total_cnt++; if (S_TREADY !== 1'b1) $display("FAIL fpop_tready got=%0b exp=1", S_TREADY); else pass_cnt++;
        total_cnt++; if (M_TDATA !== 32'h201) $display("FAIL fpop_head got=%h exp=201", M_TDATA); else pass_cnt++;
        M_TREADY = 1'b0;
        tick();
        S_TVALID = 1'b0;
        total_cnt++; if (COUNT !== 4'd8) $display("FAIL fpop_count8 got=%0d exp=8", COUNT); else pass_cnt++;
        M_TREADY = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            total_cnt++; if (M_TDATA !== ((i == 8) ? 32'h2FF : 32'h200 + 32'(i))) $display("FAIL fpop_drain i=%0d got=%h", i, M_TDATA); else pass_cnt++;
            tick();
        end
        M_TREADY = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        M_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            S_TDATA = 32'h300 + 32'(i); S_TVALID = 1'b1;
            tick();
        end
        S_TVALID = 1'b0;
        total_cnt++; if (COUNT !== 4'd5) $display("FAIL rmid_pre_count got=%0d exp=5", COUNT); else pass_cnt++;
        #2;
        ARST = 1'b1;
        #1;
        total_cnt++; if (COUNT !== 4'd0) $display("FAIL rmid_count got=%0d exp=0", COUNT); else pass_cnt++;
        total_cnt++; if (M_TVALID !== 1'b0) $display("FAIL rmid_valid got=%0b exp=0", M_TVALID); else pass_cnt++;
        total_cnt++; if (M_TDATA !== 32'd0) $display("FAIL rmid_data got=%h exp=0", M_TDATA); else pass_cnt++;
        tick();
        ARST = 1'b0;
        S_TDATA = 32'h400; S_TVALID = 1'b1;
        tick();
        S_TVALID = 1'b0;
        total_cnt++; if (M_TDATA !== 32'h400) $display("FAIL rmid_first_beat got=%h exp=400", M_TDATA); else pass_cnt++;
        total_cnt++; if (COUNT !== 4'd1) $display("FAIL rmid_post_count got=%0d exp=1", COUNT); else pass_cnt++;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_fill();
        test_wrap_simultaneous();
        test_full_pop_same_edge();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
